if_prefetch_queue: RTL and testbench
====================================

// Module: if_prefetch_queue
// PURPOSE
//  Parametrised instruction-fetch stage with a prefetch queue. Generates sequential
//  fetch PCs, issues one-outstanding requests to the memory controller over the
//  req/done handshake, and buffers returned {pc,inst} pairs in a DEPTH-entry FIFO.
//  Sits between the memory controller and ID; redirects and flushes on jump from EX.
// PARAMETERS
//  XLEN      32   address/instruction width
//  DEPTH     4    queue entries; power of two, >= 2
//  RESET_PC  0    first fetch address after reset
//  PC_STEP   4    sequential PC increment
// PORTS
//  clk          in   1     clock, all state on rising edge
//  rst          in   1     asynchronous, active-low reset
//  stall_i      in   1     pipeline stall from ctrl; blocks pop only
//  jump_i       in   1     redirect request (single cycle)
//  jump_addr_i  in   XLEN  redirect target
//  mem_req_o    out  1     fetch request pulse to memory controller
//  mem_addr_o   out  XLEN  fetch address, held stable until next request
//  mem_done_i   in   1     single-cycle completion pulse; mem_inst_i valid with it
//  mem_inst_i   in   XLEN  fetched instruction
//  id_ready_i   in   1     ID can accept an instruction
//  inst_valid_o out  1     head entry valid
//  inst_o       out  XLEN  head instruction (0 when !inst_valid_o)
//  pc_o         out  XLEN  head PC (0 when !inst_valid_o)
//  if_stall_o   out  1     = !inst_valid_o
// BEHAVIOUR
//  Reset: mem_req_o=0, mem_addr_o=0, fetch_pc=RESET_PC, queue empty (count=0,
//   rd/wr ptr=0), state=IDLE; hence inst_valid_o=0, inst_o=0, pc_o=0, if_stall_o=1.
//  FSM IDLE/WAIT/DROP:
//   IDLE: if !jump_i && count<DEPTH -> edge sets mem_req_o=1, mem_addr_o=fetch_pc,
//         state=WAIT. Otherwise mem_req_o=0.
//   WAIT: mem_req_o=0 after one cycle (strict 1-cycle pulse). On mem_done_i: push
//         {fetch_pc,mem_inst_i}, fetch_pc+=PC_STEP (mod 2^XLEN), state=IDLE.
//         Space is guaranteed: count cannot grow while WAIT.
//   DROP: on mem_done_i discard data, state=IDLE. No push.
//  Jump (highest priority, any state, regardless of stall_i): queue cleared, any
//   same-cycle push/pop ignored, fetch_pc=jump_addr_i. IDLE->IDLE (request to
//   jump_addr_i issues next cycle); WAIT without mem_done_i -> DROP; WAIT with
//   mem_done_i same cycle -> IDLE, data discarded; DROP stays DROP.
//  Pop: inst_valid_o && id_ready_i && !stall_i && !jump_i. Push and pop may occur
//   in the same cycle (count unchanged). Pointers wrap modulo DEPTH.
//  Head outputs combinational from queue head; inst_valid_o=(count!=0).
//  Best-case latency request->head visible: 1 cycle after mem_done_i edge.
//  Throughput: at most one request in flight; one instruction per mem round trip.
//  mem_done_i in IDLE is a protocol violation: ignored.
// CONFIGURATION
//  IF_BYPASS_EN defined: when count==0, state==WAIT, mem_done_i=1 and !jump_i,
//   inst_valid_o=1, inst_o=mem_inst_i, pc_o=fetch_pc in the same cycle; if popped
//   that cycle the entry is not written to the queue, else it is pushed as normal.
//  IF_BYPASS_EN undefined: outputs come only from the queue; data visible the cycle
//   after mem_done_i. All other behaviour identical.
// TESTING
//  1 Reset: rst=0 mid-WAIT with 2 entries -> immediately inst_valid_o=0, mem_req_o=0;
//    after release first mem_addr_o=RESET_PC(0), mem_req_o high exactly 1 cycle.
//  2 Fill: id_ready_i=0, memory answers 2 cycles after each req with inst=0x13+pc
//    -> 4 pushes, pcs 0,4,8,12; no 5th request while count==4; if_stall_o=0.
//  3 Drain+refill: full queue, id_ready_i=1 -> pops in order 0,4,8,12; next request
//    addr 16 issues the cycle after the first pop.
//  4 Jump in WAIT: req at 0x8 pending, jump_i addr 0x100 -> queue empty, returning
//    data dropped (DROP), next request addr 0x100, first popped pc_o=0x100.
//  5 Stall: stall_i=1, id_ready_i=1 with 3 entries -> no pop, count stays 3; jump_i
//    during stall still flushes and redirects.
//  6 Bypass (IF_BYPASS_EN): empty queue, mem_done_i inst 0x00500093 pc 0x20,
//    id_ready_i=1 -> inst_valid_o=1 same cycle, next cycle count=0; without macro
//    inst_valid_o rises one cycle later.

Source files
------------

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch stage: one-outstanding sequential fetcher feeding a DEPTH-entry {pc,inst} queue.
// Define IF_BYPASS_EN to forward returning data straight to the head outputs when the queue is empty.
module if_prefetch_queue #(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_addr_i,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_done_i,
    input  logic [XLEN-1:0] mem_inst_i,
    input  logic            id_ready_i,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic            if_stall_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;

    state_e          state_q;
    logic            mem_req_q;
    logic [XLEN-1:0] mem_addr_q;
    logic [XLEN-1:0] fetch_pc_q;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] inst_mem [DEPTH];

    logic head_valid, done_ok, byp, pop, q_pop, push;

    assign head_valid = (count_q != '0);
    assign done_ok    = (state_q == WAIT) && mem_done_i && !jump_i;

`ifdef IF_BYPASS_EN
    assign byp = !head_valid && done_ok;
`else
    assign byp = 1'b0;
`endif

    assign inst_valid_o = head_valid || byp;
    assign if_stall_o   = !inst_valid_o;
    assign inst_o = byp ? mem_inst_i : (head_valid ? inst_mem[rd_ptr_q] : '0);
    assign pc_o   = byp ? fetch_pc_q : (head_valid ? pc_mem[rd_ptr_q]   : '0);

    assign pop   = inst_valid_o && id_ready_i && !stall_i && !jump_i;
    // A bypassed instruction consumed this cycle never enters the queue.
    assign q_pop = pop && head_valid;
    assign push  = done_ok && !(byp && pop);

    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (jump_i) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push)  wr_ptr_d = wr_ptr_q + 1'b1;
            if (q_pop) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push) - CW'(q_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= fetch_pc_q;
            inst_mem[wr_ptr_q] <= mem_inst_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            fetch_pc_q <= RESET_PC;
        end else begin
            case (state_q)
                IDLE: begin
                    if (jump_i) begin
                        mem_req_q  <= 1'b0;
                        fetch_pc_q <= jump_addr_i;
                    end else if (count_q < CW'(DEPTH)) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= fetch_pc_q;
                        state_q    <= WAIT;
                    end else begin
                        mem_req_q  <= 1'b0;
                    end
                end
                WAIT: begin
                    mem_req_q <= 1'b0;
                    if (jump_i) begin
                        fetch_pc_q <= jump_addr_i;
                        state_q    <= mem_done_i ? IDLE : DROP;
                    end else if (mem_done_i) begin
                        fetch_pc_q <= fetch_pc_q + XLEN'(PC_STEP);
                        state_q    <= IDLE;
                    end
                end
                DROP: begin
                    mem_req_q <= 1'b0;
                    if (jump_i)     fetch_pc_q <= jump_addr_i;
                    if (mem_done_i) state_q    <= IDLE;
                end
                default: begin
                    mem_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomised bench for if_prefetch_queue against a queue-based reference model.
module tb_if_prefetch_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i = 1'b0, jump_i = 1'b0, mem_done_i = 1'b0, id_ready_i = 1'b0;
    logic [31:0] jump_addr_i = '0, mem_inst_i = '0;
    logic        mem_req_o, inst_valid_o, if_stall_o;
    logic [31:0] mem_addr_o, inst_o, pc_o;

    if_prefetch_queue dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .jump_i(jump_i), .jump_addr_i(jump_addr_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_done_i(mem_done_i),
        .mem_inst_i(mem_inst_i), .id_ready_i(id_ready_i), .inst_valid_o(inst_valid_o),
        .inst_o(inst_o), .pc_o(pc_o), .if_stall_o(if_stall_o)
    );

    always #5 clk = ~clk;

`ifdef IF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int passed = 0;
    int total  = 0;

    // reference model
    logic [31:0] mq_pc[$];
    logic [31:0] mq_inst[$];
    logic [31:0] m_fetch, m_addr;
    bit          m_req, m_busy, m_drop;
    // memory responder
    bit          pend;
    int          dly;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        mq_pc.delete(); mq_inst.delete();
        m_fetch = 32'h0; m_addr = 32'h0;
        m_req = 0; m_busy = 0; m_drop = 0;
        pend = 0; dly = 0;
    endtask

    // One clock cycle, entered and left at posedge+1.
    task automatic cycle(input bit ready, input bit stall, input bit jump, input logic [31:0] jaddr);
        int  sz;
        bit  byp, valid, pop, done;
        logic [31:0] einst, epc, din;
        if (mem_req_o) begin pend = 1; dly = $urandom_range(0, 2); end
        done = 0; din = $urandom;
        if (pend) begin
            if (dly == 0) begin done = 1; pend = 0; end
            else dly--;
        end
        mem_done_i = done; mem_inst_i = din;
        id_ready_i = ready; stall_i = stall; jump_i = jump; jump_addr_i = jaddr;
        @(negedge clk);
        sz    = mq_pc.size();
        byp   = BYP && sz == 0 && m_busy && !m_drop && done && !jump;
        valid = (sz != 0) || byp;
        einst = byp ? din     : (sz != 0 ? mq_inst[0] : 32'h0);
        epc   = byp ? m_fetch : (sz != 0 ? mq_pc[0]   : 32'h0);
        chk("inst_valid", {31'b0, inst_valid_o}, {31'b0, valid});
        chk("if_stall",   {31'b0, if_stall_o},   {31'b0, !valid});
        chk("inst",       inst_o, einst);
        chk("pc",         pc_o,   epc);
        chk("mem_req",    {31'b0, mem_req_o},    {31'b0, m_req});
        chk("mem_addr",   mem_addr_o, m_addr);
        pop = valid && ready && !stall && !jump;
        if (jump) begin
            mq_pc.delete(); mq_inst.delete();
            if (m_busy && done) begin m_busy = 0; m_drop = 0; end
            else if (m_busy) m_drop = 1;
            m_fetch = jaddr; m_req = 0;
        end else begin
            if (pop && sz != 0) begin void'(mq_pc.pop_front()); void'(mq_inst.pop_front()); end
            if (!m_busy) begin
                if (sz < 4) begin m_req = 1; m_addr = m_fetch; m_busy = 1; end
                else m_req = 0;
            end else begin
                m_req = 0;
                if (done) begin
                    if (!m_drop) begin
                        if (!(byp && pop)) begin mq_pc.push_back(m_fetch); mq_inst.push_back(din); end
                        m_fetch = m_fetch + 32'd4;
                    end
                    m_busy = 0; m_drop = 0;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic rnd_cycle();
        bit j = ($urandom_range(0, 99) < 6);
        cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 20, j,
              {$urandom_range(0, 255), 2'b00} << 4);
    endtask

    initial begin
        bit hit;
        model_reset();
        #2;
        chk("rst_valid", {31'b0, inst_valid_o}, 32'h0);
        chk("rst_stall", {31'b0, if_stall_o},   32'h1);
        chk("rst_req",   {31'b0, mem_req_o},    32'h0);
        chk("rst_addr",  mem_addr_o, 32'h0);
        chk("rst_inst",  inst_o, 32'h0);
        chk("rst_pc",    pc_o,   32'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 40; i++) cycle(0, 0, 0, 32'h0);   // fill until full
        chk("fill_count", mq_pc.size(), 32'd4);
        for (int i = 0; i < 40; i++) cycle(1, 0, 0, 32'h0);   // drain/refill
        for (int i = 0; i < 20; i++) cycle(1, 1, 0, 32'h0);   // stalled, no pops
        cycle(1, 1, 1, 32'h100);                             // jump under stall
        for (int i = 0; i < 400; i++) rnd_cycle();

        // async reset while waiting with two entries queued
        cycle(0, 0, 1, 32'h40);
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (mq_pc.size() == 2 && m_busy && !m_drop) hit = 1;
            else cycle(0, 0, 0, 32'h0);
        end
        chk("reach_wait2", {31'b0, hit}, 32'h1);
        @(negedge clk);
        mem_done_i = 0; rst = 1'b0;
        #1;
        chk("amid_valid", {31'b0, inst_valid_o}, 32'h0);
        chk("amid_req",   {31'b0, mem_req_o},    32'h0);
        chk("amid_addr",  mem_addr_o, 32'h0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 300; i++) rnd_cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
